gen3_rx_descrambler: RTL and testbench



---
 rtl/gen3_rx_descrambler.sv | 213 +++++++++++++++++++++
 tb/tb_gen3_rx_descrambler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/gen3_rx_descrambler.sv
// Gen3 128b/130b receive descrambler, one lane, 2 symbols per pclk, one registered stage.
// Define RX_LFSR_CHECK_EN to compare SKP LFSR symbols against the local LFSR.
module gen3_rx_descrambler #(
  parameter logic [22:0] RESET_SEED    = 23'h1DBFBC,
  parameter int unsigned SKP_MAX_WORDS = 12
) (
  input  logic        pclk,
  input  logic        reset_n,
  input  logic [22:0] seed_value,
  input  logic        scrambler_reset,
  input  logic        rx_valid,
  input  logic        rx_sync_valid,
  input  logic [1:0]  rx_sync_header,
  input  logic [15:0] rx_data,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        data_is_os,
  output logic        block_start,
  output logic        block_err,
  output logic        lfsr_mismatch
);

  typedef enum logic [1:0] {StIdle, StData, StOs, StSkp} state_e;

  localparam int unsigned CntW    = $clog2(SKP_MAX_WORDS + 9);
  localparam logic [22:0] Taps    = 23'h210125;
  localparam logic [7:0]  SymSkp  = 8'hAA;
  localparam logic [7:0]  SymEnd  = 8'hE1;
  localparam logic [7:0]  SymEie  = 8'h00;

  // {next_state, keystream}; keystream bit i scrambles rx bit i.
  function automatic logic [38:0] lfsr_step16(input logic [22:0] s);
    logic [22:0] l;
    logic [15:0] ks;
    l  = s;
    ks = '0;
    for (int i = 0; i < 16; i++) begin
      ks[i] = l[22];
      l     = {l[21:0], 1'b0} ^ (l[22] ? Taps : 23'h0);
    end
    return {l, ks};
  endfunction

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              need_sync_q, need_sync_d;
  logic              eieos_q, eieos_d;
  logic              skp_end_q, skp_end_d;
  logic [22:0]       lfsr_q, lfsr_d, lfsr_adv;
  logic [15:0]       ks;
  logic [15:0]       data_q, data_d;
  logic              valid_q, valid_d, os_q, os_d, start_q, start_d, err_q, err_d;
`ifdef RX_LFSR_CHECK_EN
  logic [7:0]        s1_q, s1_d;
  logic              mm_q, mm_d;
`endif

  always_comb begin
    {lfsr_adv, ks} = lfsr_step16(lfsr_q);
    state_d     = state_q;
    cnt_d       = cnt_q;
    need_sync_d = need_sync_q;
    eieos_d     = eieos_q;
    skp_end_d   = skp_end_q;
    lfsr_d      = lfsr_q;
    data_d      = '0;
    valid_d     = 1'b0;
    os_d        = 1'b0;
    start_d     = 1'b0;
    err_d       = 1'b0;
`ifdef RX_LFSR_CHECK_EN
    s1_d        = s1_q;
    mm_d        = 1'b0;
`endif
    if (rx_valid) begin
      if (rx_sync_valid) begin
        // A header arriving before the current block finished forces realignment.
        if (state_q != StIdle && !need_sync_q) err_d = 1'b1;
        cnt_d       = CntW'(1);
        need_sync_d = 1'b0;
        eieos_d     = 1'b0;
        skp_end_d   = 1'b0;
        case (rx_sync_header)
          2'b10: begin
            state_d = StData;
            data_d  = rx_data ^ ks;
            lfsr_d  = lfsr_adv;
            valid_d = 1'b1;
            start_d = 1'b1;
          end
          2'b01: begin
            data_d  = rx_data;
            valid_d = 1'b1;
            start_d = 1'b1;
            os_d    = 1'b1;
            if (rx_data[7:0] == SymSkp) begin
              state_d = StSkp;
            end else begin
              state_d = StOs;
              lfsr_d  = lfsr_adv;
              eieos_d = (rx_data[7:0] == SymEie);
            end
          end
          default: begin
            state_d = StIdle;
            cnt_d   = '0;
            err_d   = 1'b1;
          end
        endcase
      end else if (state_q != StIdle) begin
        if (need_sync_q) begin
          state_d     = StIdle;
          cnt_d       = '0;
          need_sync_d = 1'b0;
          err_d       = 1'b1;
        end else begin
          case (state_q)
            StData: begin
              data_d      = rx_data ^ ks;
              valid_d     = 1'b1;
              lfsr_d      = lfsr_adv;
              cnt_d       = cnt_q + CntW'(1);
              need_sync_d = (cnt_q == CntW'(7));
            end
            StOs: begin
              data_d      = rx_data;
              valid_d     = 1'b1;
              os_d        = 1'b1;
              lfsr_d      = (eieos_q && cnt_q == CntW'(7)) ? seed_value : lfsr_adv;
              cnt_d       = cnt_q + CntW'(1);
              need_sync_d = (cnt_q == CntW'(7));
            end
            StSkp: begin
              if (cnt_q >= CntW'(SKP_MAX_WORDS)) begin
                state_d = StIdle;
                cnt_d   = '0;
                err_d   = 1'b1;
              end else begin
                data_d  = rx_data;
                valid_d = 1'b1;
                os_d    = 1'b1;
                cnt_d   = cnt_q + CntW'(1);
                if (skp_end_q) begin
                  need_sync_d = 1'b1;
`ifdef RX_LFSR_CHECK_EN
                  // S1[7] is parity and not part of the LFSR image.
                  mm_d = (s1_q[6:0] != lfsr_q[22:16]) || (rx_data[7:0] != lfsr_q[15:8]) ||
                         (rx_data[15:8] != lfsr_q[7:0]);
`endif
                end else if (rx_data[7:0] == SymEnd) begin
                  skp_end_d = 1'b1;
`ifdef RX_LFSR_CHECK_EN
                  s1_d      = rx_data[15:8];
`endif
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
    if (scrambler_reset) lfsr_d = seed_value;
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      need_sync_q <= 1'b0;
      eieos_q     <= 1'b0;
      skp_end_q   <= 1'b0;
      lfsr_q      <= RESET_SEED;
      data_q      <= '0;
      valid_q     <= 1'b0;
      os_q        <= 1'b0;
      start_q     <= 1'b0;
      err_q       <= 1'b0;
`ifdef RX_LFSR_CHECK_EN
      s1_q        <= '0;
      mm_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      need_sync_q <= need_sync_d;
      eieos_q     <= eieos_d;
      skp_end_q   <= skp_end_d;
      lfsr_q      <= lfsr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      os_q        <= os_d;
      start_q     <= start_d;
      err_q       <= err_d;
`ifdef RX_LFSR_CHECK_EN
      s1_q        <= s1_d;
      mm_q        <= mm_d;
`endif
    end
  end

  assign data_out    = data_q;
  assign data_valid  = valid_q;
  assign data_is_os  = os_q;
  assign block_start = start_q;
  assign block_err   = err_q;
`ifdef RX_LFSR_CHECK_EN
  assign lfsr_mismatch = mm_q;
`else
  assign lfsr_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_gen3_rx_descrambler.sv
// Bench for gen3_rx_descrambler: a transmit-side keystream model scrambles random payloads,
// and each received word is checked against the payload or pass-through value.
module tb_gen3_rx_descrambler;

  localparam logic [22:0] SEED0 = 23'h1DBFBC;
  localparam logic [22:0] TAPS  = (23'd1 << 0) | (23'd1 << 2) | (23'd1 << 5) | (23'd1 << 8) |
                                  (23'd1 << 16) | (23'd1 << 21);
`ifdef RX_LFSR_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic        pclk, reset_n, scrambler_reset, rx_valid, rx_sync_valid;
  logic [22:0] seed_value;
  logic [1:0]  rx_sync_header;
  logic [15:0] rx_data, data_out;
  logic        data_valid, data_is_os, block_start, block_err, lfsr_mismatch;

  gen3_rx_descrambler #(.RESET_SEED(SEED0), .SKP_MAX_WORDS(12)) dut (
    .pclk            (pclk),
    .reset_n         (reset_n),
    .seed_value      (seed_value),
    .scrambler_reset (scrambler_reset),
    .rx_valid        (rx_valid),
    .rx_sync_valid   (rx_sync_valid),
    .rx_sync_header  (rx_sync_header),
    .rx_data         (rx_data),
    .data_out        (data_out),
    .data_valid      (data_valid),
    .data_is_os      (data_is_os),
    .block_start     (block_start),
    .block_err       (block_err),
    .lfsr_mismatch   (lfsr_mismatch)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [22:0] m_lfsr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Transmit keystream: 16 serial steps of the Gen3 generator, first symbol first.
  task automatic gen_ks(output logic [15:0] k);
    logic b;
    for (int i = 0; i < 16; i++) begin
      b      = m_lfsr[22];
      k[i]   = b;
      m_lfsr = {m_lfsr[21:0], 1'b0};
      if (b) m_lfsr = m_lfsr ^ TAPS;
    end
  endtask

  task automatic send(input logic sv, input logic [1:0] hdr, input logic [15:0] d,
                      input logic ev, input logic eos, input logic est, input logic eerr,
                      input logic [15:0] edata, input logic emm, input string tag);
    rx_valid       = 1'b1;
    rx_sync_valid  = sv;
    rx_sync_header = hdr;
    rx_data        = d;
    @(posedge pclk);
    #1;
    rx_valid      = 1'b0;
    rx_sync_valid = 1'b0;
    chk({tag, "_valid"}, 32'(data_valid), 32'(ev));
    chk({tag, "_os"}, 32'(data_is_os), 32'(eos));
    chk({tag, "_start"}, 32'(block_start), 32'(est));
    chk({tag, "_err"}, 32'(block_err), 32'(eerr));
    chk({tag, "_mm"}, 32'(lfsr_mismatch), 32'(emm));
    if (ev) chk({tag, "_data"}, 32'(data_out), 32'(edata));
  endtask

  task automatic idle_cycle(input string tag);
    rx_valid = 1'b0;
    @(posedge pclk);
    #1;
    chk({tag, "_stall_valid"}, 32'(data_valid), 32'd0);
    chk({tag, "_stall_err"}, 32'(block_err), 32'd0);
  endtask

  task automatic data_block(input logic zero_rx, input int stall_at, input string tag);
    logic [15:0] k, pay;
    for (int i = 0; i < 8; i++) begin
      if (i == stall_at) begin
        idle_cycle(tag);
        idle_cycle(tag);
      end
      gen_ks(k);
      pay = zero_rx ? k : 16'($urandom);
      send(i == 0, 2'b10, pay ^ k, 1'b1, 1'b0, i == 0, 1'b0, pay, 1'b0,
           $sformatf("%s_w%0d", tag, i));
    end
  endtask

  task automatic skp_block(input logic corrupt, input string tag);
    logic [7:0] s1, s2, s3;
    logic [15:0] w [4];
    s1 = {^m_lfsr[22:16], m_lfsr[22:16]};
    s2 = m_lfsr[15:8];
    s3 = m_lfsr[7:0];
    if (corrupt) s2 = s2 ^ 8'h10;
    w[0] = 16'hAAAA;
    w[1] = 16'hAAAA;
    w[2] = {s1, 8'hE1};
    w[3] = {s3, s2};
    for (int i = 0; i < 4; i++)
      send(i == 0, 2'b01, w[i], 1'b1, 1'b1, i == 0, 1'b0, w[i], (i == 3) && corrupt && CHK,
           $sformatf("%s_w%0d", tag, i));
  endtask

  task automatic os_block(input logic [7:0] sym0, input string tag);
    logic [15:0] k, w;
    for (int i = 0; i < 8; i++) begin
      w = (i == 0) ? {8'($urandom), sym0} : 16'($urandom);
      if (sym0 == 8'h00 && i == 7) m_lfsr = seed_value;
      else gen_ks(k);
      send(i == 0, 2'b01, w, 1'b1, 1'b1, i == 0, 1'b0, w, 1'b0, $sformatf("%s_w%0d", tag, i));
    end
  endtask

  initial begin
    logic [15:0] k, pay;
    reset_n         = 1'b0;
    scrambler_reset = 1'b0;
    rx_valid        = 1'b0;
    rx_sync_valid   = 1'b0;
    rx_sync_header  = 2'b00;
    rx_data         = 16'h0;
    seed_value      = 23'h0;
    m_lfsr          = SEED0;
    #2;
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_os", 32'(data_is_os), 32'd0);
    chk("rst_start", 32'(block_start), 32'd0);
    chk("rst_err", 32'(block_err), 32'd0);
    chk("rst_mm", 32'(lfsr_mismatch), 32'd0);
    repeat (2) @(posedge pclk);
    #1;
    reset_n = 1'b1;

    data_block(1'b1, -1, "ks_seed");

    seed_value      = 23'h0607BB;
    scrambler_reset = 1'b1;
    @(posedge pclk);
    #1;
    scrambler_reset = 1'b0;
    m_lfsr          = seed_value;
    chk("sreset_valid", 32'(data_valid), 32'd0);
    data_block(1'b0, -1, "loop0");
    data_block(1'b0, 4, "loop1");
    data_block(1'b0, -1, "loop2");

    skp_block(1'b0, "skp");
    data_block(1'b0, -1, "after_skp");

    os_block(8'h2D, "os");
    data_block(1'b0, -1, "after_os");

    seed_value = 23'($urandom) | 23'd1;
    os_block(8'h00, "eieos");
    data_block(1'b0, -1, "after_eieos");

    skp_block(1'b1, "skp_bad");
    data_block(1'b0, -1, "after_skp_bad");

    // Last word of a block followed by a word without a sync header.
    send(1'b0, 2'b10, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0, "nosync");
    send(1'b0, 2'b10, 16'h5678, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, "idle_word0");
    data_block(1'b0, -1, "after_nosync");

    // Sync header at word 3 realigns, then a bad header drops to idle.
    for (int i = 0; i < 3; i++) begin
      gen_ks(k);
      pay = 16'($urandom);
      send(i == 0, 2'b10, pay ^ k, 1'b1, 1'b0, i == 0, 1'b0, pay, 1'b0,
           $sformatf("pre_realign_w%0d", i));
    end
    gen_ks(k);
    pay = 16'($urandom);
    send(1'b1, 2'b10, pay ^ k, 1'b1, 1'b0, 1'b1, 1'b1, pay, 1'b0, "realign");
    for (int i = 1; i < 8; i++) begin
      gen_ks(k);
      pay = 16'($urandom);
      send(1'b0, 2'b10, pay ^ k, 1'b1, 1'b0, 1'b0, 1'b0, pay, 1'b0,
           $sformatf("realigned_w%0d", i));
    end
    send(1'b1, 2'b11, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0, "badhdr");
    send(1'b0, 2'b10, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, "idle_word1");
    data_block(1'b0, -1, "after_badhdr");

    // SKP without an end marker overruns its length limit.
    for (int i = 0; i < 12; i++)
      send(i == 0, 2'b01, 16'hAAAA, 1'b1, 1'b1, i == 0, 1'b0, 16'hAAAA, 1'b0,
           $sformatf("skp_long_w%0d", i));
    send(1'b0, 2'b01, 16'hAAAA, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0, "skp_over");
    data_block(1'b0, -1, "after_skp_over");

    // Asynchronous reset in the middle of a data block.
    for (int i = 0; i < 4; i++) begin
      gen_ks(k);
      pay = 16'($urandom);
      send(i == 0, 2'b10, pay ^ k, 1'b1, 1'b0, i == 0, 1'b0, pay, 1'b0,
           $sformatf("pre_rst_w%0d", i));
    end
    reset_n = 1'b0;
    #2;
    chk("midrst_data", 32'(data_out), 32'd0);
    chk("midrst_valid", 32'(data_valid), 32'd0);
    chk("midrst_start", 32'(block_start), 32'd0);
    @(posedge pclk);
    #1;
    reset_n = 1'b1;
    m_lfsr  = SEED0;
    data_block(1'b1, -1, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
